vip_frame_ctrl: RTL and testbench
=================================

Name: vip_frame_ctrl

Overview:
Frame-level sequencer for the VIP colour-space pipeline (RGB888 to YCbCr444, 3-cycle latency). It watches the pre-processing sync signals, admits or drops whole frames by skip ratio, and latches the conversion mode only at frame start. It holds the datapath enable through pipeline drain, checks frame geometry, and reports per-frame status to the ISP control logic.

Parameters:
IMG_H_DISP, 640, expected pixels per line (clken-qualified)
IMG_V_DISP, 480, expected lines per frame
CNT_W, 12, width of pixel and line counters
PIPE_LAT, 3, datapath latency in clocks, held as drain time
TIMEOUT_CYC, 1048576, watchdog limit (optional feature only)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  high for the duration of a frame
per_frame_href  in  1  line valid
per_frame_clken  in  1  pixel valid
cfg_enable  in  1  admit new frames
cfg_mode  in  2  0=RGB bypass, 1=YCbCr444, 2=Y-only gray, 3 treated as 1
cfg_skip  in  4  process 1 of every cfg_skip+1 frames
err_clr  in  1  clear sticky errors
proc_en  out  1  datapath enable / output gate
mode_sel  out  2  mode applied to current frame
frame_done  out  1  one-cycle pulse after the drain completes
frame_cnt  out  16  processed-frame count, wraps
last_pix_cnt  out  CNT_W  pixel count of the last line of the last frame
last_line_cnt  out  CNT_W  line count of the last frame
err_flags  out  4  sticky flags: [0] h size, [1] v size, [2] overrun, [3] timeout

Behaviour:
- Reset: all outputs 0, state WAIT_SOF, skip_cnt 0. Internal vsync_d and href_d reset to 1, so no false SOF or line-end occurs if vsync is high at reset release.
- Edge definitions: sof = vsync & ~vsync_d; eof = ~vsync & vsync_d; line_end = ~href & href_d.
- WAIT_SOF: on sof with cfg_enable=1:
  - If skip_cnt==0: go to ACTIVE, latch mode_sel (3 maps to 1), proc_en<=1, skip_cnt<=cfg_skip, clear counters.
  - Otherwise: go to SKIP and decrement skip_cnt.
  - On sof with cfg_enable=0: stay in WAIT_SOF.
- ACTIVE:
  - pix_cnt increments on href & clken and saturates at 2^CNT_W-1.
  - On line_end: if pix_cnt != IMG_H_DISP, set err[0]; line_cnt++ (saturating); pix_cnt<=0.
  - On eof: if line_cnt != IMG_V_DISP, set err[1]. If line_end occurs in the same cycle, the incremented line_cnt is used. Latch last_* counts, load drain counter with PIPE_LAT, go to DRAIN.
- DRAIN: proc_en stays 1; decrement each clock. At zero: frame_done=1 for one cycle, frame_cnt++, proc_en<=0.
  - Next state is SKIP if a sof arrived during DRAIN, else WAIT_SOF.
  - A sof during DRAIN also sets err[2] and drops that frame.
- SKIP: proc_en=0; mode_sel holds its previous value; on eof go to WAIT_SOF.
- cfg_enable and cfg_skip are sampled only at sof. Deasserting cfg_enable mid-frame lets the current frame complete normally.
- mode_sel changes only on an accepted sof.
- err_clr clears all err_flags bits. If an error event and err_clr occur in the same cycle, the set wins.
- Asynchronous reset mid-frame: proc_en drops immediately. After release the block waits for a fresh sof; the frame in progress is ignored.

Optional Feature:
VIP_FRAME_CTRL_TIMEOUT_EN:
- Defined: a watchdog counts clocks in ACTIVE since the last href & clken or eof, and reloads on either event. On reaching TIMEOUT_CYC it sets err[3], forces proc_en=0, does not pulse frame_done and does not increment frame_cnt, then goes to SKIP to resync at the next eof.
- Undefined: there is no watchdog logic, err[3] is tied to 0, and ACTIVE waits for eof indefinitely.

Test Plan:
- Params H=8, V=4; cfg_skip=0, cfg_mode=1; one 8x4 frame -> proc_en rises in the sof cycle; frame_done pulses 3 clocks after eof, then frame_cnt=1, last_pix_cnt=8, last_line_cnt=4, err_flags=0.
- cfg_skip=2; 6 back-to-back frames -> frames 1 and 4 processed, frame_cnt=2, proc_en low for all other frames.
- Line 2 carries 7 pixels and the frame has 3 lines -> err_flags=4'b0011, sticky across the next clean frame. err_clr pulse -> 0.
- cfg_mode switched 1 to 2 mid-frame -> mode_sel stays 1 until the next accepted sof, then 2. cfg_mode=3 -> mode_sel=1.
- eof followed by vsync low 1 clock and a new sof -> err[2] set; the second frame is dropped (proc_en stays 0 through it); frame_cnt=1.
- rst_n asserted mid-ACTIVE with vsync held high across release -> outputs 0 immediately, no sof until vsync falls and rises again. With VIP_FRAME_CTRL_TIMEOUT_EN, TIMEOUT_CYC=16 and clken held low 16 clocks in ACTIVE -> err[3]=1, proc_en=0, no frame_done.

Source files
------------

// File: rtl/vip_frame_ctrl.sv
// vip_frame_ctrl
// Frame-level sequencer for the RGB888 -> YCbCr444 colour-space pipeline.
// It admits or drops whole frames by skip ratio and latches the conversion
// mode at frame start. It holds the datapath enable while the pipeline
// drains, checks frame geometry and reports per-frame status.
// Build option: define VIP_FRAME_CTRL_TIMEOUT_EN to add the ACTIVE-state
// watchdog. The watchdog raises err_flags[3] and abandons a stalled frame.
module vip_frame_ctrl #(
  parameter int IMG_H_DISP  = 640,
  parameter int IMG_V_DISP  = 480,
  parameter int CNT_W       = 12,
  parameter int PIPE_LAT    = 3,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             cfg_enable,
  input  logic [1:0]       cfg_mode,
  input  logic [3:0]       cfg_skip,
  input  logic             err_clr,
  output logic             proc_en,
  output logic [1:0]       mode_sel,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] last_pix_cnt,
  output logic [CNT_W-1:0] last_line_cnt,
  output logic [3:0]       err_flags
);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DRAIN    = 2'd2,
    SKIP     = 2'd3
  } state_e;

  localparam int DRN_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PIPE_LAT);
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] H_EXP    = CNT_W'(IMG_H_DISP);
  localparam logic [CNT_W-1:0] V_EXP    = CNT_W'(IMG_V_DISP);

  state_e           state_q, state_d;
  logic             vsync_q, href_q;
  logic [3:0]       skip_q, skip_d;
  logic [1:0]       mode_q, mode_d;
  logic             proc_en_q, proc_en_d;
  logic             done_q, done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] line_pix_q, line_pix_d;
  logic [CNT_W-1:0] last_pix_q, last_pix_d;
  logic [CNT_W-1:0] last_line_q, last_line_d;
  logic [3:0]       err_q, err_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             ovr_q, ovr_d;

  logic             sof, eof, line_end, pix_valid, ovr_now;
  logic [3:0]       err_set;
  logic [CNT_W-1:0] line_inc, line_fin;

  assign sof       = per_frame_vsync & ~vsync_q;
  assign eof       = ~per_frame_vsync & vsync_q;
  assign line_end  = ~per_frame_href & href_q;
  assign pix_valid = per_frame_href & per_frame_clken;

`ifdef VIP_FRAME_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog count of idle clocks while a frame is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // Sync history resets high so a vsync/href already high at release is not taken as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      href_q  <= 1'b1;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
    end
  end

  // Sequencer state and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_SOF;
      skip_q      <= '0;
      mode_q      <= '0;
      proc_en_q   <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      line_pix_q  <= '0;
      last_pix_q  <= '0;
      last_line_q <= '0;
      err_q       <= '0;
      drain_q     <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      mode_q      <= mode_d;
      proc_en_q   <= proc_en_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      line_pix_q  <= line_pix_d;
      last_pix_q  <= last_pix_d;
      last_line_q <= last_line_d;
      err_q       <= err_d;
      drain_q     <= drain_d;
      ovr_q       <= ovr_d;
    end
  end

  // Next-state logic: frame admission, geometry counting, drain and error flags
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    mode_d      = mode_q;
    proc_en_d   = proc_en_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    pix_d       = pix_q;
    line_d      = line_q;
    line_pix_d  = line_pix_q;
    last_pix_d  = last_pix_q;
    last_line_d = last_line_q;
    drain_d     = drain_q;
    ovr_d       = ovr_q;
    err_set     = 4'b0000;
    line_inc    = (line_q == CNT_MAX) ? line_q : line_q + 1'b1;
    line_fin    = line_q;
    ovr_now     = 1'b0;
`ifdef VIP_FRAME_CTRL_TIMEOUT_EN
    wd_d        = wd_q;
`endif

    case (state_q)
      WAIT_SOF: begin
        if (sof && cfg_enable) begin
          if (skip_q == 4'd0) begin
            state_d    = ACTIVE;
            mode_d     = (cfg_mode == 2'd3) ? 2'd1 : cfg_mode;
            proc_en_d  = 1'b1;
            skip_d     = cfg_skip;
            pix_d      = '0;
            line_d     = '0;
            line_pix_d = '0;
`ifdef VIP_FRAME_CTRL_TIMEOUT_EN
            wd_d       = '0;
`endif
          end else begin
            state_d = SKIP;
            skip_d  = skip_q - 4'd1;
          end
        end
      end

      ACTIVE: begin
        if (pix_valid && (pix_q != CNT_MAX)) pix_d = pix_q + 1'b1;
        if (line_end) begin
          if (pix_q != H_EXP) err_set[0] = 1'b1;
          line_d     = line_inc;
          line_pix_d = pix_q;
          pix_d      = '0;
        end
        if (eof) begin
          line_fin    = line_end ? line_inc : line_q;
          if (line_fin != V_EXP) err_set[1] = 1'b1;
          last_line_d = line_fin;
          last_pix_d  = line_end ? pix_q : line_pix_q;
          drain_d     = DRN_LOAD;
          ovr_d       = 1'b0;
          state_d     = DRAIN;
        end
`ifdef VIP_FRAME_CTRL_TIMEOUT_EN
        if (pix_valid || eof) begin
          wd_d = '0;
        end else if (wd_q >= WD_LAST) begin
          err_set[3] = 1'b1;
          proc_en_d  = 1'b0;
          state_d    = SKIP;
          wd_d       = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end

      DRAIN: begin
        // A frame that starts during drain is dropped; if it also ends during drain there is nothing left to skip
        ovr_now = (ovr_q & ~eof) | sof;
        ovr_d   = ovr_now;
        if (sof) err_set[2] = 1'b1;
        if (drain_q <= DRN_ONE) begin
          drain_d     = '0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          proc_en_d   = 1'b0;
          ovr_d       = 1'b0;
          state_d     = ovr_now ? SKIP : WAIT_SOF;
        end else begin
          drain_d = drain_q - DRN_ONE;
        end
      end

      SKIP: begin
        proc_en_d = 1'b0;
        if (eof) state_d = WAIT_SOF;
      end

      default: state_d = WAIT_SOF;
    endcase

    err_d = (err_clr ? 4'b0000 : err_q) | err_set;
`ifndef VIP_FRAME_CTRL_TIMEOUT_EN
    err_d[3] = 1'b0;
`endif
  end

  assign proc_en       = proc_en_q;
  assign mode_sel      = mode_q;
  assign frame_done    = done_q;
  assign frame_cnt     = frame_cnt_q;
  assign last_pix_cnt  = last_pix_q;
  assign last_line_cnt = last_line_q;
  assign err_flags     = err_q;

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Testbench for vip_frame_ctrl (default build, small 8x4 geometry).
// The stimulus side pushes expected per-frame reports into a queue as each
// frame ends. A monitor pops them whenever frame_done pulses.
module tb_vip_frame_ctrl;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int CW  = 12;
  localparam int LAT = 3;

  logic          clk;
  logic          rst_n;
  logic          vsync, href, clken, cfgEnable, errClr;
  logic [1:0]    cfgMode;
  logic [3:0]    cfgSkip;
  logic          procEn;
  logic [1:0]    modeSel;
  logic          frameDone;
  logic [15:0]   frameCnt;
  logic [CW-1:0] lastPix, lastLine;
  logic [3:0]    errFlags;

  vip_frame_ctrl #(
    .IMG_H_DISP (H),
    .IMG_V_DISP (V),
    .CNT_W      (CW),
    .PIPE_LAT   (LAT),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(vsync),
    .per_frame_href (href),
    .per_frame_clken(clken),
    .cfg_enable     (cfgEnable),
    .cfg_mode       (cfgMode),
    .cfg_skip       (cfgSkip),
    .err_clr        (errClr),
    .proc_en        (procEn),
    .mode_sel       (modeSel),
    .frame_done     (frameDone),
    .frame_cnt      (frameCnt),
    .last_pix_cnt   (lastPix),
    .last_line_cnt  (lastLine),
    .err_flags      (errFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cnt;
    int pix;
    int lines;
    int err;
    int mode;
    int doneCyc;
  } frame_exp_t;

  frame_exp_t expQ[$];
  int lineLens[$];
  int total = 0;
  int bad = 0;
  int doneSeen = 0;
  int doneExpected = 0;

  // reference model of the frame-level rules
  int mSkip = 0;
  int mErr = 0;
  int mFrames = 0;
  int mMode = 0;
  bit mDropNext = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // decides whether the frame now starting is processed
  function automatic bit modelSof();
    bit acc;
    acc = 1'b0;
    if (mDropNext) begin
      mDropNext = 1'b0;
    end else if (cfgEnable) begin
      if (mSkip == 0) begin
        acc   = 1'b1;
        mSkip = int'(cfgSkip);
        mMode = (cfgMode == 2'd3) ? 1 : int'(cfgMode);
      end else begin
        mSkip--;
      end
    end
    return acc;
  endfunction

  // one frame built from lineLens; tail = idle clocks between last href fall and vsync fall
  task automatic applyStimulus(input int tail, input int gap, input bit modeSwitch, input int stallPct);
    bit acc;
    bit dropping;
    int errBits;
    int pc;
    int lastIdx;
    dropping = mDropNext;
    vsync = 1'b1;
    acc = modelSof();
    tick();
    if (!dropping) checkOutput("proc_en_sof", procEn, acc);
    errBits = 0;
    lastIdx = lineLens.size() - 1;
    for (int i = 0; i <= lastIdx; i++) begin
      if (lineLens[i] != H) errBits |= 1;
      href = 1'b1;
      pc = 0;
      while (pc < lineLens[i]) begin
        clken = ($urandom_range(99) >= stallPct);
        if (clken) pc++;
        tick();
      end
      href  = 1'b0;
      clken = 1'b0;
      if (i == 0) begin
        checkOutput("proc_en_mid", procEn, acc);
        if (modeSwitch) cfgMode = 2'd2;
      end
      if (i != lastIdx) begin
        tick();
        tick();
      end
    end
    repeat (tail) tick();
    vsync = 1'b0;
    if (lineLens.size() != V) errBits |= 2;
    if (acc) begin
      if (gap <= LAT) begin
        errBits  |= 4;
        mDropNext = 1'b1;
      end
      mErr   |= errBits;
      mFrames = (mFrames + 1) & 16'hFFFF;
      expQ.push_back('{mFrames, lineLens[lastIdx], lineLens.size(), mErr, mMode, cyc + 1 + LAT});
      doneExpected++;
    end
    repeat (gap) tick();
  endtask

  task automatic pulseErrClr();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    mErr = 0;
    checkOutput("err_after_clr", errFlags, mErr);
  endtask

  task automatic setLines(input int n, input int len);
    lineLens.delete();
    for (int i = 0; i < n; i++) lineLens.push_back(len);
  endtask

  // monitor: every frame_done pulse must match the oldest expected report
  initial begin
    frame_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && frameDone === 1'b1) begin
        doneSeen++;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: frame_done=1 with no frame pending (t=%0t)", $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_cycle", cyc, e.doneCyc);
          checkOutput("frame_cnt", frameCnt, e.cnt);
          checkOutput("last_pix_cnt", lastPix, e.pix);
          checkOutput("last_line_cnt", lastLine, e.lines);
          checkOutput("err_flags", errFlags, e.err);
          checkOutput("mode_sel", modeSel, e.mode);
        end
      end
    end
  end

  initial begin
    bit accExp;
    int nLines;
    int r;
    rst_n = 1'b0;
    vsync = 1'b0; href = 1'b0; clken = 1'b0;
    cfgEnable = 1'b0; errClr = 1'b0; cfgMode = 2'd0; cfgSkip = 4'd0;
    repeat (3) tick();
    checkOutput("rst_proc_en", procEn, 0);
    checkOutput("rst_mode_sel", modeSel, 0);
    checkOutput("rst_frame_done", frameDone, 0);
    checkOutput("rst_frame_cnt", frameCnt, 0);
    checkOutput("rst_last_pix", lastPix, 0);
    checkOutput("rst_last_line", lastLine, 0);
    checkOutput("rst_err", errFlags, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // basic 8x4 frame
    cfgEnable = 1'b1; cfgMode = 2'd1; cfgSkip = 4'd0;
    setLines(V, H);
    applyStimulus(1, 6, 1'b0, 0);

    // skip ratio 1 of 3 over six frames
    cfgSkip = 4'd2;
    for (int f = 0; f < 6; f++) applyStimulus(1, 5, 1'b0, 20);
    cfgSkip = 4'd0;
    checkOutput("frame_cnt_after_skip", frameCnt, 3);

    // short line and short frame, then a clean frame with line end coinciding with eof
    lineLens.delete();
    lineLens.push_back(8); lineLens.push_back(7); lineLens.push_back(8);
    applyStimulus(1, 6, 1'b0, 10);
    setLines(V, H);
    applyStimulus(0, 6, 1'b0, 10);
    checkOutput("err_sticky", errFlags, mErr);
    pulseErrClr();

    // mode only changes at an accepted frame start
    cfgMode = 2'd1;
    applyStimulus(2, 5, 1'b1, 0);
    applyStimulus(1, 5, 1'b0, 0);
    cfgMode = 2'd3;
    applyStimulus(1, 5, 1'b0, 0);

    // new frame one clock after eof: overrun and dropped frame
    applyStimulus(1, 1, 1'b0, 0);
    applyStimulus(1, 6, 1'b0, 0);
    checkOutput("err_overrun", errFlags, mErr);
    pulseErrClr();

    // disabled frame is not processed
    cfgEnable = 1'b0;
    applyStimulus(1, 5, 1'b0, 0);
    cfgEnable = 1'b1;

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      cfgSkip = 4'($urandom_range(1));
      cfgMode = 2'($urandom_range(3));
      nLines = int'($urandom_range(5, 3));
      lineLens.delete();
      for (int i = 0; i < nLines; i++) begin
        r = int'($urandom_range(9));
        lineLens.push_back((r == 0) ? 7 : ((r == 1) ? 9 : H));
      end
      applyStimulus(int'($urandom_range(2)), int'($urandom_range(7, 4)), 1'b0, int'($urandom_range(40)));
      if ($urandom_range(2) == 0) pulseErrClr();
    end

    // settle skip history so the next frame is admitted
    cfgSkip = 4'd0;
    setLines(V, H);
    applyStimulus(1, 5, 1'b0, 0);
    checkOutput("queue_empty_pre_reset", expQ.size(), 0);

    // reset in the middle of an active frame, vsync held high across release
    vsync = 1'b1;
    accExp = modelSof();
    tick();
    href = 1'b1; clken = 1'b1;
    repeat (3) tick();
    checkOutput("proc_en_pre_reset", procEn, accExp);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_proc_en", procEn, 0);
    checkOutput("reset_frame_cnt", frameCnt, 0);
    checkOutput("reset_err", errFlags, 0);
    checkOutput("reset_mode", modeSel, 0);
    mSkip = 0; mErr = 0; mFrames = 0; mMode = 0; mDropNext = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    href = 1'b0; clken = 1'b0;
    tick();
    tick();
    checkOutput("proc_en_ignored_frame", procEn, 0);
    vsync = 1'b0;
    repeat (5) tick();
    cfgMode = 2'd2;
    applyStimulus(1, 6, 1'b0, 10);

    repeat (10) tick();
    checkOutput("pending_reports", expQ.size(), 0);
    checkOutput("done_count", doneSeen, doneExpected);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
